// File: rtl/text_pkg.sv
// Shared constants, control codes and state encoding for the text-mode screen buffer.
// Shared with the pixel encoder (row/column geometry).
package text_pkg;

    localparam int unsigned COLS      = 40;
    localparam int unsigned ROWS      = 15;
    localparam int unsigned COL_W     = 6;
    localparam int unsigned ROW_W     = 4;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned CHAR_ID_W = 8;
    localparam int unsigned CELLS     = COLS * ROWS;

    localparam logic [CHAR_ID_W-1:0] BLANK_ID = 8'h20;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_CLEAR,
        ST_SCROLL
    } state_e;

    // Linear buffer address of a (row, col) cell.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/text_buffer_ctrl_if.sv
// Byte-stream valid/ready handshake from the keyboard/UART receiver.
//   rx_data  : incoming byte          (master -> slave)
//   rx_valid : rx_data valid          (master -> slave)
//   rx_ready : slave accepts this cycle (slave -> master)
interface text_buffer_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input  rx_ready);
    modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/text_ram.sv
// 600 x 8 character store: one synchronous write port, two asynchronous read ports.
//   we/waddr/wdata   : write port (clk)
//   raddr_a/rdata_a  : display read
//   raddr_b/rdata_b  : scroll source read
// Addresses beyond the last cell read as BLANK_ID and are never written.
module text_ram
    import text_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [CHAR_ID_W-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr_a,
    output logic [CHAR_ID_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0]    raddr_b,
    output logic [CHAR_ID_W-1:0] rdata_b
);

    logic [CHAR_ID_W-1:0] mem [CELLS];

    always_ff @(posedge clk) begin
        if (we && (waddr < ADDR_W'(CELLS))) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a < ADDR_W'(CELLS)) ? mem[raddr_a] : BLANK_ID;
    assign rdata_b = (raddr_b < ADDR_W'(CELLS)) ? mem[raddr_b] : BLANK_ID;

endmodule

// File: rtl/text_buffer_ctrl.sv
// 40x15 text screen buffer controller: byte-stream command interpreter, cursor,
// line wrap, scroll and clear, plus a zero-latency character lookup for the pixel encoder.
//   clk, reset            : clock, synchronous active-high reset
//   rx (slave)            : rx_data / rx_valid / rx_ready byte handshake
//   char_row, char_col    : display read coordinates
//   character_id          : combinational cell contents (BLANK_ID when out of range)
//   cursor_row/cursor_col : current cursor
//   busy                  : high while clearing or scrolling
module text_buffer_ctrl
    import text_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    text_buffer_ctrl_if.slave     rx,
    input  logic [ROW_W-1:0]      char_row,
    input  logic [COL_W-1:0]      char_col,
    output logic [CHAR_ID_W-1:0]  character_id,
    output logic [ROW_W-1:0]      cursor_row,
    output logic [COL_W-1:0]      cursor_col,
    output logic                  busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] COPY_END  = ADDR_W'(COLS * (ROWS - 1));
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [7:0]          byte_q, byte_d;
    logic                rx_ready_q, rx_ready_d;
    logic                busy_q, busy_d;

    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [CHAR_ID_W-1:0] wdata;
    logic [ADDR_W-1:0]   disp_addr;
    logic [CHAR_ID_W-1:0] disp_data;
    logic [ADDR_W-1:0]   src_addr;
    logic [CHAR_ID_W-1:0] src_data;
    logic                disp_in_range;

    text_ram u_ram (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (disp_addr),
        .rdata_a (disp_data),
        .raddr_b (src_addr),
        .rdata_b (src_data)
    );

    // Display lookup; coordinates outside the screen read blank.
    assign disp_in_range = (char_row < ROW_W'(ROWS)) && (char_col < COL_W'(COLS));
    assign disp_addr     = cell_addr(char_row, char_col);
    assign character_id  = disp_in_range ? disp_data : BLANK_ID;

    // Scroll copies each cell from the one a full line below.
    assign src_addr = cnt_q + ADDR_W'(COLS);

    // Next-state, cursor, counter and write-port control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        byte_d  = byte_q;
        we      = 1'b0;
        waddr   = cell_addr(row_q, col_q);
        wdata   = byte_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rx.rx_valid && rx_ready_q) begin
                    byte_d  = rx.rx_data;
                    state_d = ST_CMD;
                end
            end

            ST_CMD: begin
                state_d = ST_IDLE;
                if ((byte_q >= 8'h20) && (byte_q <= 8'h7E)) begin
                    we = 1'b1;
                    if (col_q < LAST_COL) begin
                        col_d = col_q + COL_W'(1);
                    end else if (row_q < LAST_ROW) begin
                        row_d = row_q + ROW_W'(1);
                        col_d = '0;
                    end else begin
                        // Cursor parks at (14,39) until the scroll completes.
                        state_d = ST_SCROLL;
                        cnt_d   = '0;
                    end
                end else if ((byte_q == CC_LF) || (byte_q == CC_CR)) begin
                    if (row_q < LAST_ROW) begin
                        row_d = row_q + ROW_W'(1);
                        col_d = '0;
                    end else begin
                        state_d = ST_SCROLL;
                        cnt_d   = '0;
                    end
                end else if (byte_q == CC_BS) begin
                    if (col_q != '0) begin
                        col_d = col_q - COL_W'(1);
                        we    = 1'b1;
                        waddr = cell_addr(row_q, col_q - COL_W'(1));
                        wdata = BLANK_ID;
                    end else if (row_q != '0) begin
                        row_d = row_q - ROW_W'(1);
                        col_d = LAST_COL;
                        we    = 1'b1;
                        waddr = cell_addr(row_q - ROW_W'(1), LAST_COL);
                        wdata = BLANK_ID;
                    end
                end else if (byte_q == CC_FF) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end

            ST_CLEAR: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = BLANK_ID;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

            ST_SCROLL: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = (cnt_q < COPY_END) ? src_data : BLANK_ID;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    row_d   = LAST_ROW;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

            default: state_d = ST_CLEAR;
        endcase

        rx_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d == ST_CLEAR) || (state_d == ST_SCROLL);
    end

    // State and registered outputs; reset restarts a full clear from address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            byte_q     <= '0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            byte_q     <= byte_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign rx.rx_ready = rx_ready_q;
    assign cursor_row  = row_q;
    assign cursor_col  = col_q;
    assign busy        = busy_q;

endmodule

// File: doc/text_buffer_ctrl.md
Name: text_buffer_ctrl

Overview:
- Owns the 40x15 character screen buffer that feeds the text-mode pixel encoder.
- Accepts a byte stream from the keyboard/UART receiver over a valid/ready handshake and interprets control codes.
- Maintains the cursor, performs line wrap, scroll and clear, and serves combinational character_id lookups to the pixel encoder on a dedicated read port.

Parameters:
- COLS, 40, characters per line
- ROWS, 15, lines on screen
- COL_W, 6, width of column index
- ROW_W, 4, width of row index
- ADDR_W, 10, buffer address width (covers COLS*ROWS = 600)
- CHAR_ID_W, 8, character id width
- BLANK_ID, 8'h20, id written by clear/scroll/backspace

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block can accept a byte this cycle
- char_row  in  ROW_W  display read row, from pixel encoder
- char_col  in  COL_W  display read column, from pixel encoder
- character_id  out  CHAR_ID_W  buffer[char_row*COLS+char_col], combinational
- cursor_row  out  ROW_W  current cursor row
- cursor_col  out  COL_W  current cursor column
- busy  out  1  high in CLEAR or SCROLL

Behaviour:
- Interface: one clock, `clk`. Reset is synchronous and active-high, port `reset`.
- Storage: 600 x 8 array, addr = row*COLS + col.
  - One synchronous write port.
  - Two asynchronous read ports: display, and scroll source.
- Display read:
  - Combinational, zero latency.
  - Out-of-range row/col (row>=15 or col>=40) returns BLANK_ID.
- Reset:
  - cursor = (0,0), rx_ready = 0, busy = 1.
  - State goes to CLEAR.
  - Reset asserted in any state (including mid-SCROLL) aborts the operation and restarts CLEAR from address 0.
- States: IDLE, CMD, CLEAR, SCROLL.
- IDLE:
  - rx_ready = 1.
  - On rx_valid & rx_ready, latch the byte and go to CMD.
  - No other state asserts rx_ready; rx_valid outside IDLE is ignored (sender holds).
- CMD (one cycle), acting on the latched byte:
  - 0x20..0x7E printable: write byte at cursor. If col<39: col+1. Else if row<14: (row+1,0). Else (row 14, col 39): go SCROLL, cursor becomes (14,0) at SCROLL end.
  - 0x0A or 0x0D newline: if row<14: (row+1,0). Else go SCROLL.
  - 0x08 backspace: if col>0: col-1 and write BLANK_ID at the new position. Else if row>0: (row-1,39) and write BLANK_ID there. At (0,0): no-op.
  - 0x0C form feed: go CLEAR.
  - Any other byte: ignored.
  - Return to IDLE unless SCROLL or CLEAR was entered.
- Throughput: at most one byte per 2 cycles. A write in CMD is visible on character_id the cycle after the CMD edge.
- CLEAR:
  - Counter 0..599, writes BLANK_ID, one cell per cycle (600 cycles).
  - Then cursor = (0,0), go IDLE.
- SCROLL:
  - Phase 1, copy: counter 0..559, buffer[a] <= buffer[a+40].
  - Phase 2, blank: counter 560..599, writes BLANK_ID.
  - 600 cycles total; then cursor = (14,0), go IDLE.
- Display reads during CLEAR/SCROLL see partially updated contents. Tearing is accepted.
- Counters are ADDR_W bits and saturate to the terminal value; no wrap past 599.

Decomposition:
- Shared package `text_pkg`:
  - COLS, ROWS, COL_W, ROW_W, ADDR_W, CHAR_ID_W, BLANK_ID
  - control-code constants: CC_BS = 8'h08, CC_LF = 8'h0A, CC_FF = 8'h0C, CC_CR = 8'h0D
  - state encoding
- These are shared with the pixel encoder's ROW_NUMBER/COL_NUMBER.
- One sub-module: `text_ram`, 600x8 with 1 sync write and 2 async reads.
- The FSM, cursor and counter stay in text_buffer_ctrl.

Test Plan:
- Reset held 1 cycle, then 600 cycles -> busy falls, rx_ready = 1. Every (r,c) reads 0x20. Cursor (0,0).
- Send 'A' (0x41), then 'B' (0x42) -> (0,0) = 0x41, (0,1) = 0x42, cursor (0,2). rx_ready is low in each CMD cycle.
- Send 40 x 0x58 -> row 0 all 0x58, cursor (1,0). Then 0x08 -> cursor (0,39), cell (0,39) = 0x20.
- Fill rows: 15 lines, each 'L'+row then 0x0D (0x0D on row 14 last) -> SCROLL of 600 cycles, busy = 1.
  - Afterwards (0,0) = 'M' (former row 1), row 14 all 0x20, cursor (14,0).
- Send 0x0C mid-screen -> 600-cycle clear, all cells 0x20, cursor (0,0). Backspace at (0,0) -> no change.
- Assert reset at cycle 300 of SCROLL -> CLEAR restarts. After 600 cycles all cells 0x20, cursor (0,0).
  - Byte 0x07 -> ignored, cursor unchanged.
